// File: rtl/readback_pkg.sv
// -----------------------------------------------------------------------------
// readback_pkg
// Shared constants and types for the backplane readback path.
//   - Opcodes placed in the frame header (status / counters / history).
//   - Two-bit byte markers carried in bytout[9:8].
//   - Fixed word counts of the status and counter blocks.
//   - Source-select codes driven on rd_sel.
//   - Frame state enumeration used by readback_frame_tx.
// -----------------------------------------------------------------------------
package readback_pkg;

    localparam logic [7:0] OP_RDSTATUS   = 8'd20;
    localparam logic [7:0] OP_RDCOUNTERS = 8'd21;
    localparam logic [7:0] OP_HISTREAD   = 8'd29;

    localparam logic [1:0] MK_NONE = 2'd0;
    localparam logic [1:0] MK_FST  = 2'd1;
    localparam logic [1:0] MK_NXT  = 2'd2;
    localparam logic [1:0] MK_LST  = 2'd3;

    localparam int STAT_WORDS = 4;
    localparam int CNT_WORDS  = 8;

    localparam logic [1:0] SEL_STATUS   = 2'd0;
    localparam logic [1:0] SEL_COUNTERS = 2'd1;
    localparam logic [1:0] SEL_HISTORY  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR_MS = 3'd1,
        ST_HDR_LS = 3'd2,
        ST_DAT_MS = 3'd3,
        ST_DAT_LS = 3'd4,
        ST_GAP    = 3'd5
    } rb_state_t;

    // Header opcode for a given source select.
    function automatic logic [7:0] sel_opcode(input logic [1:0] sel);
        logic [7:0] op;
        case (sel)
            SEL_STATUS:   op = OP_RDSTATUS;
            SEL_COUNTERS: op = OP_RDCOUNTERS;
            SEL_HISTORY:  op = OP_HISTREAD;
            default:      op = OP_RDSTATUS;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/readback_frame_tx.sv
// -----------------------------------------------------------------------------
// readback_frame_tx
// Frame sequencer: walks IDLE -> HDR_MS -> HDR_LS -> (DAT_MS -> DAT_LS) x N
// -> GAP -> IDLE, issues source reads and formats the 10-bit return bytes.
//
// Ports
//   clk16       in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   i_start     in   begin a frame (honoured only in IDLE)
//   i_sel       in   source select for the frame being started
//   i_len       in   word count for the frame being started (must be >= 1)
//   i_src_data  in   read data of the selected source, valid the cycle after rd_en
//   o_idle      out  state register is IDLE (used for arbitration)
//   o_rd_sel    out  source select, 0 while IDLE
//   o_rd_addr   out  word address of the read being issued
//   o_rd_en     out  read strobe
//   o_bytout    out  {marker[1:0], payload[7:0]}
//   o_busy      out  state is not IDLE
// -----------------------------------------------------------------------------
module readback_frame_tx
    import readback_pkg::*;
(
    input  logic        clk16,
    input  logic        reset,
    input  logic        i_start,
    input  logic [1:0]  i_sel,
    input  logic [7:0]  i_len,
    input  logic [15:0] i_src_data,
    output logic        o_idle,
    output logic [1:0]  o_rd_sel,
    output logic [7:0]  o_rd_addr,
    output logic        o_rd_en,
    output logic [9:0]  o_bytout,
    output logic        o_busy
);

    rb_state_t   r_state;
    rb_state_t   w_state_next;
    logic [1:0]  r_sel;
    logic [7:0]  r_len;
    logic [7:0]  r_idx;
    logic [15:0] r_word;

    logic        w_last;
    logic [15:0] w_word;
    logic [9:0]  w_byte;
    logic        w_rd_en;
    logic [7:0]  w_rd_addr;

    // Current word is the final one of the frame.
    assign w_last = (r_idx == (r_len - 8'd1));

    // Source data arrives during DAT_MS; it is captured there so the LS
    // byte still sees the same word while the next read is in flight.
    assign w_word = (r_state == ST_DAT_MS) ? i_src_data : r_word;

    always_ff @(posedge clk16) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_sel   <= SEL_STATUS;
            r_len   <= 8'd0;
            r_idx   <= 8'd0;
            r_word  <= 16'd0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == ST_IDLE) && i_start) begin
                r_sel <= i_sel;
                r_len <= i_len;
            end
            if (r_state == ST_HDR_LS) begin
                r_idx <= 8'd0;
            end else if ((r_state == ST_DAT_LS) && !w_last) begin
                r_idx <= r_idx + 8'd1;
            end
            if (r_state == ST_DAT_MS) begin
                r_word <= i_src_data;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_byte       = 10'h000;
        w_rd_en      = 1'b0;
        w_rd_addr    = 8'd0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_next = ST_HDR_MS;
                end
            end
            ST_HDR_MS: begin
                w_byte       = {MK_FST, 8'h00};
                w_state_next = ST_HDR_LS;
            end
            ST_HDR_LS: begin
                w_byte       = {MK_NONE, sel_opcode(r_sel)};
                w_rd_en      = 1'b1;
                w_rd_addr    = 8'd0;
                w_state_next = ST_DAT_MS;
            end
            ST_DAT_MS: begin
                w_byte       = {(w_last ? MK_LST : MK_NXT), w_word[15:8]};
                w_state_next = ST_DAT_LS;
            end
            ST_DAT_LS: begin
                w_byte = {MK_NONE, w_word[7:0]};
                if (w_last) begin
                    w_state_next = ST_GAP;
                end else begin
                    w_rd_en      = 1'b1;
                    w_rd_addr    = r_idx + 8'd1;
                    w_state_next = ST_DAT_MS;
                end
            end
            ST_GAP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are forced quiet for as long as reset is held, so an abandoned
    // frame never shows a further byte once reset is seen.
    assign o_idle    = (r_state == ST_IDLE);
    assign o_busy    = !reset && (r_state != ST_IDLE);
    assign o_bytout  = reset ? 10'h000 : w_byte;
    assign o_rd_en   = !reset && w_rd_en;
    assign o_rd_addr = reset ? 8'd0 : w_rd_addr;
    assign o_rd_sel  = (reset || (r_state == ST_IDLE)) ? SEL_STATUS : r_sel;

endmodule

// File: rtl/readback_arbiter.sv
// -----------------------------------------------------------------------------
// readback_arbiter
// Collects one-cycle read requests for the status, counter and history blocks,
// arbitrates them in fixed priority (status > counters > history) and hands
// the winner to readback_frame_tx, which streams the frame on bytout.
//
// Build option: HISTORY_READBACK_EN
//   defined   - history requester active (hist_read / hist_len / hist_data)
//   undefined - history inputs ignored, rd_sel never selects the history block
//
// Ports
//   clk16       in   16 MHz system clock, rising edge
//   reset       in   synchronous active-high reset
//   rdstatus    in   request pulse, status block
//   rdcounters  in   request pulse, counter block
//   hist_read   in   request pulse, history block
//   hist_len    in   history word count, taken when the history frame starts
//   rd_sel      out  source select: 0 status, 1 counters, 2 history
//   rd_addr     out  word address within the selected source
//   rd_en       out  read strobe; data valid next cycle
//   stat_data   in   status block read data
//   cnt_data    in   counter block read data
//   hist_data   in   history block read data
//   bytout      out  return byte {marker[1:0], payload[7:0]}
//   busy        out  frame in progress
// -----------------------------------------------------------------------------
module readback_arbiter
    import readback_pkg::*;
(
    input  logic        clk16,
    input  logic        reset,
    input  logic        rdstatus,
    input  logic        rdcounters,
    input  logic        hist_read,
    input  logic [7:0]  hist_len,
    output logic [1:0]  rd_sel,
    output logic [7:0]  rd_addr,
    output logic        rd_en,
    input  logic [15:0] stat_data,
    input  logic [15:0] cnt_data,
    input  logic [15:0] hist_data,
    output logic [9:0]  bytout,
    output logic        busy
);

    localparam int NSRC = 3;

    logic [NSRC-1:0] r_pend;
    logic [NSRC-1:0] w_pend_next;
    logic [NSRC-1:0] w_req;
    logic [NSRC-1:0] w_clr;

    logic            w_tx_idle;
    logic            w_start;
    logic [1:0]      w_sel;
    logic [7:0]      w_len;
    logic [15:0]     w_src_data;
    logic [1:0]      w_rd_sel;

    assign w_req[0] = rdstatus;
    assign w_req[1] = rdcounters;
`ifdef HISTORY_READBACK_EN
    assign w_req[2] = hist_read;
`else
    assign w_req[2] = 1'b0;
    logic w_unused_hist;
    assign w_unused_hist = ^{hist_read, hist_len, hist_data};
`endif

    // A pulse that lands on the grant edge of its own source wins over the
    // clear, so it is kept as a further frame rather than lost.
    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_pend
            assign w_pend_next[gi] = (r_pend[gi] & ~w_clr[gi]) | w_req[gi];
        end
    endgenerate

    always_ff @(posedge clk16) begin
        if (reset) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_next;
        end
    end

    // Fixed-priority grant, evaluated only while the sequencer sits in IDLE.
    always_comb begin
        w_start = 1'b0;
        w_sel   = SEL_STATUS;
        w_len   = 8'd0;
        w_clr   = '0;
        if (w_tx_idle) begin
            if (r_pend[0]) begin
                w_start  = 1'b1;
                w_sel    = SEL_STATUS;
                w_len    = 8'(STAT_WORDS);
                w_clr[0] = 1'b1;
            end else if (r_pend[1]) begin
                w_start  = 1'b1;
                w_sel    = SEL_COUNTERS;
                w_len    = 8'(CNT_WORDS);
                w_clr[1] = 1'b1;
`ifdef HISTORY_READBACK_EN
            end else if (r_pend[2]) begin
                // An empty history is consumed without sending a frame.
                w_clr[2] = 1'b1;
                if (hist_len != 8'd0) begin
                    w_start = 1'b1;
                    w_sel   = SEL_HISTORY;
                    w_len   = hist_len;
                end
`endif
            end
        end
    end

    // Return-data mux follows the select the sequencer is driving.
    always_comb begin
        w_src_data = stat_data;
        case (w_rd_sel)
            SEL_COUNTERS: w_src_data = cnt_data;
`ifdef HISTORY_READBACK_EN
            SEL_HISTORY:  w_src_data = hist_data;
`endif
            default:      w_src_data = stat_data;
        endcase
    end

    readback_frame_tx u_frame_tx (
        .clk16      (clk16),
        .reset      (reset),
        .i_start    (w_start),
        .i_sel      (w_sel),
        .i_len      (w_len),
        .i_src_data (w_src_data),
        .o_idle     (w_tx_idle),
        .o_rd_sel   (w_rd_sel),
        .o_rd_addr  (rd_addr),
        .o_rd_en    (rd_en),
        .o_bytout   (bytout),
        .o_busy     (busy)
    );

    assign rd_sel = w_rd_sel;

endmodule

// File: tb/tb_readback_arbiter.sv
// -----------------------------------------------------------------------------
// tb_readback_arbiter
// Directed + randomized bench for readback_arbiter. Source blocks are modelled
// as registered-read memories; the expected byte stream is built from the
// frame format rules (header, marked data words, gap) in request priority order.
// History cases are compiled in only when HISTORY_READBACK_EN is defined.
// -----------------------------------------------------------------------------
module tb_readback_arbiter;

`ifdef HISTORY_READBACK_EN
    localparam bit HIST_EN = 1'b1;
`else
    localparam bit HIST_EN = 1'b0;
`endif

    logic        clk16 = 1'b0;
    logic        reset;
    logic        rdstatus, rdcounters, hist_read;
    logic [7:0]  hist_len;
    logic [1:0]  rd_sel;
    logic [7:0]  rd_addr;
    logic        rd_en;
    logic [15:0] stat_data = 16'h0;
    logic [15:0] cnt_data  = 16'h0;
    logic [15:0] hist_data = 16'h0;
    logic [9:0]  bytout;
    logic        busy;

    logic [15:0] stat_mem [256];
    logic [15:0] cnt_mem  [256];
    logic [15:0] hist_mem [256];

    logic [9:0]  got_q [$];
    logic [9:0]  exp_q [$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic        sel2_seen = 1'b0;

    always #5 clk16 = ~clk16;

    readback_arbiter dut (
        .clk16      (clk16),
        .reset      (reset),
        .rdstatus   (rdstatus),
        .rdcounters (rdcounters),
        .hist_read  (hist_read),
        .hist_len   (hist_len),
        .rd_sel     (rd_sel),
        .rd_addr    (rd_addr),
        .rd_en      (rd_en),
        .stat_data  (stat_data),
        .cnt_data   (cnt_data),
        .hist_data  (hist_data),
        .bytout     (bytout),
        .busy       (busy)
    );

    // Registered-read source blocks.
    always @(posedge clk16) begin
        if (rd_en === 1'b1) begin
            case (rd_sel)
                2'd0:    stat_data <= stat_mem[rd_addr];
                2'd1:    cnt_data  <= cnt_mem[rd_addr];
                2'd2:    hist_data <= hist_mem[rd_addr];
                default: ;
            endcase
        end
    end

    always @(negedge clk16) begin
        if (rd_sel === 2'd2) sel2_seen <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic fill_mems(input bit constant_status);
        for (int i = 0; i < 256; i++) begin
            stat_mem[i] = constant_status ? 16'hA5C3 : 16'($urandom);
            cnt_mem[i]  = 16'($urandom);
            hist_mem[i] = 16'($urandom);
        end
    endtask

    // Reference: one complete frame followed by its gap byte.
    task automatic add_frame(input int src, input int n);
        logic [15:0] w;
        logic [7:0]  op;
        op = (src == 0) ? 8'd20 : (src == 1) ? 8'd21 : 8'd29;
        exp_q.push_back(10'h100);
        exp_q.push_back({2'b00, op});
        for (int k = 0; k < n; k++) begin
            w = (src == 0) ? stat_mem[k] : (src == 1) ? cnt_mem[k] : hist_mem[k];
            exp_q.push_back({((k == n - 1) ? 2'b11 : 2'b10), w[15:8]});
            exp_q.push_back({2'b00, w[7:0]});
        end
        exp_q.push_back(10'h000);
    endtask

    // Expected stream for a set of simultaneous requests.
    task automatic build_expected(input logic [2:0] mask, input int hlen);
        exp_q.delete();
        if (mask[0]) add_frame(0, 4);
        if (mask[1]) add_frame(1, 8);
        if (mask[2] && HIST_EN && hlen != 0) add_frame(2, hlen);
    endtask

    task automatic pulse(input logic [2:0] m);
        {hist_read, rdcounters, rdstatus} = m;
        @(negedge clk16);
        {hist_read, rdcounters, rdstatus} = 3'b000;
    endtask

    // Records every byte seen while busy or non-zero until the block has been
    // quiet for 8 cycles; optionally pulses requests at a given cycle.
    task automatic collect(input int budget, input int pulse_at, input logic [2:0] pmask,
                           output int first_cyc);
        int quiet;
        int cyc;
        quiet = 0;
        cyc = 0;
        first_cyc = -1;
        got_q.delete();
        while (cyc < budget && quiet < 8) begin
            @(negedge clk16);
            {hist_read, rdcounters, rdstatus} = 3'b000;
            if (busy === 1'b1 || bytout !== 10'h000) begin
                got_q.push_back(bytout);
                quiet = 0;
                if (first_cyc < 0) first_cyc = cyc;
            end else begin
                quiet++;
            end
            if (cyc == pulse_at) {hist_read, rdcounters, rdstatus} = pmask;
            cyc++;
        end
        check("collect_done", 32'(quiet >= 8), 32'd1);
        check("idle_rd_sel", 32'(rd_sel), 32'd0);
        check("idle_rd_addr", 32'(rd_addr), 32'd0);
        check("idle_rd_en", 32'(rd_en), 32'd0);
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s_b%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        end
    endtask

    initial begin
        int          first;
        logic [2:0]  mask;
        int          hlen;
        logic [9:0]  ref032 [11];

        ref032 = '{10'h100, 10'h014, 10'h2A5, 10'h0C3, 10'h2A5, 10'h0C3,
                   10'h2A5, 10'h0C3, 10'h3A5, 10'h0C3, 10'h000};
        reset = 1'b1;
        {hist_read, rdcounters, rdstatus} = 3'b000;
        hist_len = 8'd0;
        fill_mems(1'b1);

        // Reset state.
        repeat (3) @(negedge clk16);
        check("rst_bytout", 32'(bytout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_rd_sel", 32'(rd_sel), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        reset = 1'b0;
        @(negedge clk16);

        // Status frame with constant data; HDR_MS must appear two edges after the pulse.
        pulse(3'b001);
        collect(200, -1, 3'b000, first);
        check("status_latency", 32'(first), 32'd0);
        exp_q.delete();
        for (int i = 0; i < 11; i++) exp_q.push_back(ref032[i]);
        compare_stream("status_const");
        $display("txn status_const: bytes=%0d first_cyc=%0d", got_q.size(), first);

        // Counters frame re-requested mid-frame -> a second counters frame.
        fill_mems(1'b0);
        pulse(3'b010);
        collect(300, 5, 3'b010, first);
        exp_q.delete();
        add_frame(1, 8);
        add_frame(1, 8);
        compare_stream("cnt_repulse");
        $display("txn cnt_repulse: bytes=%0d", got_q.size());

`ifdef HISTORY_READBACK_EN
        // All three requests together, history of two words.
        hist_len = 8'd2;
        pulse(3'b111);
        collect(300, -1, 3'b000, first);
        build_expected(3'b111, 2);
        compare_stream("all_three");
        $display("txn all_three: bytes=%0d", got_q.size());

        // Empty history: no frame, and the request must not linger.
        hist_len = 8'd0;
        pulse(3'b100);
        collect(40, -1, 3'b000, first);
        check("hist0_no_frame", 32'(got_q.size()), 32'd0);
        hist_len = 8'd3;
        collect(40, -1, 3'b000, first);
        check("hist0_pend_clr", 32'(got_q.size()), 32'd0);
        $display("txn hist_len0: bytes=%0d", got_q.size());
`else
        // History requests are ignored in this build.
        hist_len = 8'd3;
        pulse(3'b100);
        collect(40, -1, 3'b000, first);
        check("nohist_no_frame", 32'(got_q.size()), 32'd0);
        $display("txn nohist: bytes=%0d", got_q.size());
`endif

        // Reset at the third DAT_MS of a counters frame.
        fill_mems(1'b0);
        pulse(3'b010);
        repeat (7) @(negedge clk16);
        check("rstmid_dat_ms2", 32'(bytout), 32'({2'b10, cnt_mem[2][15:8]}));
        reset = 1'b1;
        @(negedge clk16);
        check("rstmid_bytout", 32'(bytout), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        @(negedge clk16);
        reset = 1'b0;
        collect(60, -1, 3'b000, first);
        check("rstmid_no_resume", 32'(got_q.size()), 32'd0);
        $display("txn reset_mid_frame: bytes_after=%0d", got_q.size());

        // Randomized simultaneous request sets.
        for (int t = 0; t < 8; t++) begin
            fill_mems(1'b0);
            mask = 3'($urandom_range(1, 7));
            hlen = $urandom_range(0, 6);
            hist_len = 8'(hlen);
            pulse(mask);
            collect(400, -1, 3'b000, first);
            build_expected(mask, hlen);
            compare_stream($sformatf("rand%0d", t));
            $display("txn rand%0d: mask=%b hist_len=%0d bytes=%0d", t, mask, hlen, got_q.size());
        end

`ifndef HISTORY_READBACK_EN
        check("nohist_sel2_never", 32'(sel2_seen), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
